// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker
// Description : Game score keeper for a runner game. Counts game-step ticks
//               into BCD score points, tracks a speed level and the best
//               score since reset, and sequences IDLE / RUN / OVER.
// Revision    : 1.0 - initial release
// ============================================================================
module score_tracker #(
    parameter int DIGITS          = 2,
    parameter int TICKS_PER_POINT = 4,
    parameter int LEVEL_STEP      = 10,
    parameter int MAX_LEVEL       = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic                  start_i,
    input  logic                  collide_i,
    output logic [4*DIGITS-1:0]   score_o,
    output logic [4*DIGITS-1:0]   hi_score_o,
    output logic [2:0]            level_o,
    output logic [1:0]            state_o,
    output logic                  new_record_o,
    output logic                  score_update_o
);

    localparam int SW = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [SW-1:0] ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [7:0]    PRESC_LAST = 8'(TICKS_PER_POINT - 1);
    localparam logic [7:0]    PTS_LAST   = 8'(LEVEL_STEP - 1);
    localparam logic [2:0]    LEVEL_MAX  = 3'(MAX_LEVEL);

    logic [1:0]    state_q,  state_d;
    logic          start_q;
    logic [SW-1:0] score_q,  score_d;
    logic [SW-1:0] hi_q,     hi_d;
    logic [2:0]    level_q,  level_d;
    logic [7:0]    presc_q,  presc_d;
    logic [7:0]    pts_q,    pts_d;
    logic          newrec_q, newrec_d;
    logic          upd_q,    upd_d;

    logic          start_rise;
    logic [SW-1:0] score_inc;
    logic          inc_carry;

    assign start_rise = start_i & ~start_q;

    // Decimal +1 of the score: ripple a carry through the BCD digits
    always_comb begin
        score_inc = score_q;
        inc_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end
        end
    end

    // Game sequencing, point accumulation, level and best-score tracking
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        hi_d     = hi_q;
        level_d  = level_q;
        presc_d  = presc_q;
        pts_d    = pts_q;
        newrec_d = newrec_q;

        case (state_q)
            ST_IDLE: begin
                score_d  = '0;
                level_d  = 3'd0;
                presc_d  = 8'd0;
                pts_d    = 8'd0;
                newrec_d = 1'b0;
                if (start_rise) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (collide_i) begin
                    // Collision wins over a coincident tick; BCD packing
                    // makes a plain unsigned compare a decimal compare.
                    state_d = ST_OVER;
                    if (score_q > hi_q) begin
                        hi_d     = score_q;
                        newrec_d = 1'b1;
                    end else begin
                        newrec_d = 1'b0;
                    end
                end else if (tick_i) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = 8'd0;
                        // Points past all-nines are dropped entirely and
                        // do not advance the level either.
                        if (score_q != ALL_NINES) begin
                            score_d = score_inc;
                            if (pts_q == PTS_LAST) begin
                                pts_d = 8'd0;
                                if (level_q < LEVEL_MAX) begin
                                    level_d = level_q + 3'd1;
                                end
                            end else begin
                                pts_d = pts_q + 8'd1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
            end

            ST_OVER: begin
                if (start_rise && !collide_i) begin
                    state_d  = ST_RUN;
                    score_d  = '0;
                    level_d  = 3'd0;
                    presc_d  = 8'd0;
                    pts_d    = 8'd0;
                    newrec_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display strobe follows any edge where the score value moved
    assign upd_d = (score_d != score_q);

    // State registers with immediate clear on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            score_q  <= '0;
            hi_q     <= '0;
            level_q  <= 3'd0;
            presc_q  <= 8'd0;
            pts_q    <= 8'd0;
            newrec_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_i;
            score_q  <= score_d;
            hi_q     <= hi_d;
            level_q  <= level_d;
            presc_q  <= presc_d;
            pts_q    <= pts_d;
            newrec_q <= newrec_d;
            upd_q    <= upd_d;
        end
    end

    assign score_o        = score_q;
    assign hi_score_o     = hi_q;
    assign level_o        = level_q;
    assign state_o        = state_q;
    assign new_record_o   = newrec_q;
    assign score_update_o = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_tracker
// Description : Self-checking bench for score_tracker. A game-level model
//               (tick totals, integer scores) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_tracker;

    localparam int TPP    = 4;
    localparam int LSTEP  = 10;
    localparam int SMAX   = 99;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic       collide;

    logic [7:0] score, hi_score, score2, hi_score2;
    logic [2:0] level, level2;
    logic [1:0] state, state2;
    logic       new_record, score_update, new_record2, score_update2;

    int n_vec;
    int n_err;

    // Model state: game phase, ticks taken in the current game, best score
    int m_state;
    int m_ticks;
    int m_hi;
    bit m_newrec;
    bit m_startq;
    bit m_upd;

    score_tracker u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tick_i         (tick),
        .start_i        (start),
        .collide_i      (collide),
        .score_o        (score),
        .hi_score_o     (hi_score),
        .level_o        (level),
        .state_o        (state),
        .new_record_o   (new_record),
        .score_update_o (score_update)
    );

    score_tracker #(.MAX_LEVEL(2)) u_dut_lvl2 (
        .clk_i          (clk),
        .rst_i          (rst),
        .tick_i         (tick),
        .start_i        (start),
        .collide_i      (collide),
        .score_o        (score2),
        .hi_score_o     (hi_score2),
        .level_o        (level2),
        .state_o        (state2),
        .new_record_o   (new_record2),
        .score_update_o (score_update2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_score();
        int s;
        s = m_ticks / TPP;
        return (s > SMAX) ? SMAX : s;
    endfunction

    function automatic int m_level(input int maxl);
        int l;
        l = m_score() / LSTEP;
        return (l > maxl) ? maxl : l;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((v / 10) % 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_ticks  = 0;
        m_hi     = 0;
        m_newrec = 1'b0;
        m_startq = 1'b0;
        m_upd    = 1'b0;
    endtask

    task automatic compare_all();
        check("state",        32'(state),        32'(m_state));
        check("score",        32'(score),        32'(to_bcd(m_score())));
        check("hi_score",     32'(hi_score),     32'(to_bcd(m_hi)));
        check("level",        32'(level),        32'(m_level(7)));
        check("new_record",   32'(new_record),   32'(m_newrec));
        check("score_update", 32'(score_update), 32'(m_upd));
        check("level_max2",   32'(level2),       32'(m_level(2)));
    endtask

    // One clock of stimulus, model advance on the edge, compare after it
    task automatic step(input bit t, input bit s, input bit c);
        bit rise;
        int old_score;
        tick    = t;
        start   = s;
        collide = c;
        @(posedge clk);
        rise      = s && !m_startq;
        old_score = m_score();
        case (m_state)
            0: begin
                if (rise) begin
                    m_state = 1;
                    m_ticks = 0;
                end
            end
            1: begin
                if (c) begin
                    m_state = 2;
                    if (m_score() > m_hi) begin
                        m_hi     = m_score();
                        m_newrec = 1'b1;
                    end else begin
                        m_newrec = 1'b0;
                    end
                end else if (t) begin
                    m_ticks++;
                end
            end
            default: begin
                if (rise && !c) begin
                    m_state  = 1;
                    m_ticks  = 0;
                    m_newrec = 1'b0;
                end
            end
        endcase
        m_startq = s;
        m_upd    = (m_score() != old_score);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges must clear outputs before the next edge
    task automatic async_reset();
        #2;
        rst     = 1'b1;
        tick    = 1'b0;
        start   = 1'b0;
        collide = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        tick    = 1'b0;
        start   = 1'b0;
        collide = 1'b0;
        model_reset();

        #1 rst = 1'b1;
        #1 compare_all();
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all();

        // Start, then 8 ticks -> score 02, level 0
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        ticks(8);
        check("score_after_8", 32'(score), 32'h02);

        // Up to score 12 with prescaler at 3, then collide with a tick
        ticks(12 * TPP + 3 - 8);
        step(1'b1, 1'b0, 1'b1);
        check("over_score", 32'(score), 32'h12);
        check("over_hi", 32'(hi_score), 32'h12);
        check("over_rec", 32'(new_record), 32'h1);

        // Start while still colliding is ignored; then a clean restart
        step(1'b0, 1'b1, 1'b1);
        check("stay_over", 32'(state), 32'h2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("restart_state", 32'(state), 32'h1);

        // Short game ending at 05 keeps the record
        ticks(5 * TPP);
        step(1'b0, 1'b0, 1'b1);
        check("short_hi", 32'(hi_score), 32'h12);

        // Long game: 35 points, then well past saturation
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(35 * TPP);
        check("score_35", 32'(score), 32'h35);
        check("level_35", 32'(level), 32'h3);
        ticks(70 * TPP + 10);
        check("score_sat", 32'(score), 32'h99);

        // Game at score 20 interrupted by reset
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(20 * TPP);
        async_reset();

        // Randomised play with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 79) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD score digits (one per seven-segment display).
REQ-002 SHALL have parameter TICKS_PER_POINT, default 4, game-step ticks per score point (range 1..255).
REQ-003 SHALL have parameter LEVEL_STEP, default 10, points per speed level (range 1..255).
REQ-004 SHALL have parameter MAX_LEVEL, default 7, saturation value of level (range 0..7).
REQ-005 clock  input  1  single system clock, rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tick  input  1  game-step strobe, one clock cycle wide, same rate that drives player/enemy update.
REQ-008 start  input  1  level-sensitive start/restart request, synchronous to clock.
REQ-009 collide  input  1  collision flag (level), high while dinosaur overlaps an enemy.
REQ-010 score  output  4*DIGITS  current score, packed BCD, digit 0 in LSBs.
REQ-011 hi_score  output  4*DIGITS  best score since reset, packed BCD.
REQ-012 level  output  3  speed level for the enemy stage.
REQ-013 state  output  2  game state: 00 IDLE, 01 RUN, 10 OVER; 11 unused.
REQ-014 new_record  output  1  high in OVER when the finished game set a strictly higher hi_score.
REQ-015 score_update  output  1  one-cycle pulse telling the display stage that score changed.

Function
REQ-016 SHALL register start once and form start_rise = start & ~start_q; only start_rise SHALL cause a state change.
REQ-017 IDLE: score, level and prescaler SHALL hold 0; start_rise -> RUN on the next edge.
REQ-018 RUN: each tick with collide low SHALL advance a prescaler (0..TICKS_PER_POINT-1); a tick at terminal count SHALL wrap the prescaler to 0 and add 1 to score.
REQ-019 Score increment SHALL be decimal per digit with carry (09 -> 10, 99 saturates); at all-nines further points SHALL be dropped and no score_update pulse SHALL occur.
REQ-020 A points-since-level counter SHALL count each applied point; on reaching LEVEL_STEP it SHALL clear and level SHALL increment, saturating at MAX_LEVEL.
REQ-021 RUN with collide high SHALL go to OVER on the next edge; collide SHALL take precedence over a simultaneous tick (no prescaler or score change that cycle).
REQ-022 On the RUN->OVER edge, if score > hi_score (unsigned BCD compare) hi_score SHALL load score and new_record SHALL set to 1; otherwise both unchanged/0.
REQ-023 OVER: score, level, hi_score SHALL hold; ticks ignored.
REQ-024 OVER with start_rise and collide low SHALL go to RUN, clearing score, level, prescaler, points-since-level and new_record on that edge; start_rise with collide high SHALL be ignored.
REQ-025 score_update SHALL pulse for exactly one cycle, in the cycle after any edge on which score changed value (increment or restart clear from nonzero); never otherwise.
REQ-026 hi_score SHALL persist across restarts and clear only on reset.
REQ-027 All outputs SHALL be registered; latency tick -> score change = 1 clock edge.

Reset
REQ-028 reset high SHALL immediately (no clock edge) force state IDLE, score 0, hi_score 0, level 0, new_record 0, score_update 0, prescaler and internal counters 0, start_q 0.
REQ-029 reset asserted mid-RUN or mid-OVER SHALL abandon the game with no hi_score update; after release, block SHALL wait in IDLE for start_rise.

Verification
REQ-030 Reset, start_rise, 8 ticks (defaults) -> state 01, score 0x02, two score_update pulses, level 0.
REQ-031 Drive 35 points -> score 0x35, carry 09->10 correct, level 3; with MAX_LEVEL=2, level stays 2.
REQ-032 Drive 105 points -> score saturates 0x99, no score_update after reaching 0x99, state stays 01.
REQ-033 At score 0x12, prescaler 3: collide and tick same cycle -> score 0x12, state 10, hi_score 0x12, new_record 1.
REQ-034 In OVER: start_rise with collide high -> stays 10; collide low, start_rise -> state 01, score 0x00, hi_score 0x12, new_record 0; end next game at 0x05 -> hi_score 0x12, new_record 0.
REQ-035 Assert reset between clock edges during RUN at score 0x20 -> all outputs 0 before next edge, state 00.
